// File: rtl/score_row_buffer.sv
// Double-buffered score collector: captures a full score block in one strobe,
// streams 1/sqrt(d)-scaled rows over valid/ready. Define SCORE_ROUND_EN for round half-up; default truncates.

module score_elem_scale #(
  parameter int W = 16,
  parameter int S = 3
) (
  input  logic signed [W-1:0] x,
  output logic        [W-1:0] y
);
`ifdef SCORE_ROUND_EN
  // One extra bit of headroom so the rounding add can never wrap.
  localparam logic signed [W:0] HALF = (W+1)'(1) << (S-1);
  logic signed [W:0] sum;
  assign sum = $signed({x[W-1], x}) + HALF;
  assign y   = W'(sum >>> S);
`else
  assign y = x >>> S;
`endif
endmodule

module score_row_buffer #(
  parameter int NUM_ROWS      = 8,
  parameter int ELEM_WIDTH    = 16,
  parameter int ELEMS_PER_ROW = 16,
  parameter int SCALE_SHIFT   = 3,
  parameter int ROW_WIDTH     = ELEM_WIDTH*ELEMS_PER_ROW,
  parameter int IDX_WIDTH     = $clog2(NUM_ROWS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [NUM_ROWS-1:0][ROW_WIDTH-1:0] in_rows,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ROW_WIDTH-1:0]               out_row,
  output logic [IDX_WIDTH-1:0]               out_row_idx,
  output logic                               out_last,
  output logic                               err_drop
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ROWS-1);

  logic [1:0][NUM_ROWS-1:0][ROW_WIDTH-1:0] mem;
  logic [1:0]           full;
  logic                 wr_bank, rd_bank;
  state_t               state, state_n;
  logic                 capture, load, drain_done, clr_valid, load_bank;
  logic [IDX_WIDTH-1:0] load_idx;
  logic [ROW_WIDTH-1:0] sel_row, scaled;

  assign in_ready = ~&full;
  assign capture  = in_valid & in_ready;

  always_ff @(posedge clk)
    if (capture) mem[wr_bank] <= in_rows;

  // Capture and drain always target different banks, so both may fire on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      if (capture) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (drain_done) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (in_valid && !in_ready) err_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    drain_done = 1'b0;
    clr_valid  = 1'b0;
    load_bank  = rd_bank;
    load_idx   = out_row_idx + IDX_WIDTH'(1);
    case (state)
      IDLE: if (full[rd_bank]) begin
        load     = 1'b1;
        load_idx = '0;
        state_n  = STREAM;
      end
      STREAM: if (out_ready) begin
        if (out_row_idx == LAST_IDX) begin
          drain_done = 1'b1;
          if (full[~rd_bank]) begin
            load      = 1'b1;
            load_bank = ~rd_bank;
            load_idx  = '0;
          end else begin
            clr_valid = 1'b1;
            state_n   = IDLE;
          end
        end else begin
          load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sel_row = mem[load_bank][load_idx];

  for (genvar e = 0; e < ELEMS_PER_ROW; e++) begin : g_elem
    score_elem_scale #(.W(ELEM_WIDTH), .S(SCALE_SHIFT)) u_scale (
      .x(sel_row[e*ELEM_WIDTH +: ELEM_WIDTH]),
      .y(scaled[e*ELEM_WIDTH +: ELEM_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_row     <= scaled;
      out_row_idx <= load_idx;
      out_last    <= (load_idx == LAST_IDX);
    end else if (clr_valid) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_score_row_buffer.sv
// Randomized scoreboard bench for score_row_buffer; reference model tracks blocks
// as a queue of expected scaled rows and predicts in_ready/out_valid/err_drop.
module tb_score_row_buffer;
  localparam int NR = 8;
  localparam int EW = 16;
  localparam int EPR = 16;
  localparam int SH = 3;
  localparam int RW = EW*EPR;
  localparam int IW = $clog2(NR);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic [NR-1:0][RW-1:0]  in_rows;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          out_row;
  logic [IW-1:0]          out_row_idx;
  logic                   out_last;
  logic                   err_drop;

  score_row_buffer #(.NUM_ROWS(NR), .ELEM_WIDTH(EW), .ELEMS_PER_ROW(EPR), .SCALE_SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rows(in_rows), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct { logic [RW-1:0] row; logic [IW-1:0] idx; logic last; } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;
  int held = 0, beats = 0, pend = 0;
  logic merr = 1'b0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference scaling: integer floor division by 2^SH, optionally after adding one half.
  function automatic logic [EW-1:0] ref_scale(input logic [EW-1:0] x);
    int v, d, r;
    logic [31:0] rv;
    v = int'($signed(x));
`ifdef SCORE_ROUND_EN
    v = v + (1 << (SH-1));
`endif
    d = 1 << SH;
    if (v >= 0) r = v / d;
    else        r = -((-v + d - 1) / d);
    rv = r;
    return rv[EW-1:0];
  endfunction

  function automatic logic [RW-1:0] ref_row(input logic [RW-1:0] raw);
    logic [RW-1:0] r;
    for (int e = 0; e < EPR; e++) r[e*EW +: EW] = ref_scale(raw[e*EW +: EW]);
    return r;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic acc, exp_v;
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_err_drop", err_drop, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_row_idx", out_row_idx, 0);
      chk("rst_out_last", out_last, 0);
      q.delete(); held = 0; beats = 0; pend = 0; merr = 1'b0;
    end else begin
      acc = (held < 2);
      chk("in_ready", in_ready, acc);
      chk("err_drop", err_drop, merr);
      exp_v = (q.size() > pend);
      chk("out_valid", out_valid, exp_v);
      if (out_valid && q.size() > 0) begin
        e = q[0];
        chk("out_row", out_row, e.row);
        chk("out_row_idx", out_row_idx, e.idx);
        chk("out_last", out_last, e.last);
        if (out_ready) begin
          void'(q.pop_front());
          beats++;
          if (beats % NR == 0) held--;
        end
      end
      pend = 0;
      if (in_valid) begin
        if (acc) begin
          for (int r = 0; r < NR; r++) begin
            e.row = ref_row(in_rows[r]); e.idx = IW'(r); e.last = (r == NR-1);
            q.push_back(e);
          end
          held++;
          pend = NR;
        end else begin
          merr = 1'b1;
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < EPR; e++) in_rows[r][e*EW +: EW] = EW'($urandom);
  endtask

  initial begin
    logic [EW-1:0] c;
    in_valid = 1'b0; in_rows = '0; out_ready = 1'b0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Constant block 0x0040
    out_ready = 1'b1;
    c = 16'h0040;
    for (int r = 0; r < NR; r++) for (int e = 0; e < EPR; e++) in_rows[r][e*EW +: EW] = c;
    strobe(); idle(12);

    // Rounding corners mixed with random data
    fill_rand();
    for (int r = 0; r < NR; r++) begin
      in_rows[r][0*EW +: EW] = 16'h0004;
      in_rows[r][1*EW +: EW] = 16'hFFFC;
      in_rows[r][2*EW +: EW] = 16'h7FFF;
      in_rows[r][3*EW +: EW] = 16'h8000;
      in_rows[r][4*EW +: EW] = 16'hFFFF;
    end
    strobe(); idle(12);

    // Back-to-back blocks two cycles apart
    fill_rand(); strobe(); idle(1);
    fill_rand(); strobe(); idle(20);

    // Three strobes while stalled: third dropped
    out_ready = 1'b0;
    fill_rand(); strobe();
    fill_rand(); strobe();
    fill_rand(); strobe();
    idle(3);
    out_ready = 1'b1; idle(22);

    // Stall pattern 1,0,0,1
    fill_rand(); strobe();
    repeat (4) begin
      out_ready = 1'b1; idle(1);
      out_ready = 1'b0; idle(2);
      out_ready = 1'b1; idle(1);
    end
    idle(10);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 5) == 0);
      if (in_valid) fill_rand();
      out_ready = ($urandom_range(0, 9) < 7);
      idle(1);
    end
    in_valid = 1'b0; out_ready = 1'b1; idle(25);

    // Reset while row 3 of a block is presented
    fill_rand(); strobe(); idle(4);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    fill_rand(); strobe(); idle(12);

    chk("drain_empty", 256'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
